// File: rtl/lcd_text_pkg.sv
// Shared types and helpers for the table-driven LCD text layout controller.
// Optional hex-field support is enabled with the HEX_FIELD_EN macro.
package lcd_text_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LAT,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Entry layout is {row, col, ascii}; row offset depends on COL_W
    localparam int ASCII_LSB = 0;
    localparam int ASCII_W   = 7;
    localparam int COL_LSB   = ASCII_LSB + ASCII_W;

    localparam logic [6:0] ASCII_HEX_ESC = 7'h7F;
    localparam logic [6:0] ASCII_BLANK   = 7'h00;

    function automatic logic [6:0] hex_to_ascii(input logic [3:0] nib);
        logic [6:0] ext;
        ext = {3'b000, nib};
        if (nib < 4'd10) begin
            return 7'h30 + ext;
        end
        return 7'h37 + ext;
    endfunction

endpackage

// File: rtl/lcd_text_hex_digit.sv
// Nibble to ASCII hex digit ('0'-'9', 'A'-'F'), purely combinational.
// Only instantiated when HEX_FIELD_EN is defined.
import lcd_text_pkg::*;

module lcd_text_hex_digit (
    input  logic [3:0] nibble,
    output logic [6:0] ascii
);

    assign ascii = hex_to_ascii(nibble);

endmodule

// File: rtl/lcd_text_layout_ctrl.sv
// Walks a text-entry RAM and drives the glyph renderer with per-entry origins.
// Define HEX_FIELD_EN to turn ascii 0x7F entries into hex digits of hex_val.
import lcd_text_pkg::*;

module lcd_text_layout_ctrl #(
    parameter int FONT_W    = 8,
    parameter int FONT_H    = 16,
    parameter bit FONT_BIG  = 1'b1,
    parameter int MAX_CHARS = 32,
    parameter int COL_W     = 5,
    parameter int ROW_W     = 4,
    parameter int XY_W      = 9,
    parameter bit AUTO_RUN  = 1'b1,
    localparam int AW       = $clog2(MAX_CHARS),
    localparam int EW       = ROW_W + COL_W + 7
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            init_done,
    input  logic            refresh,
    input  logic [AW:0]     str_len,
    output logic [AW-1:0]   ent_addr,
    input  logic [EW-1:0]   ent_data,
    input  logic            show_char_done,
    output logic            en_size,
    output logic            show_char_flag,
    output logic [6:0]      ascii_num,
    output logic [XY_W-1:0] start_x,
    output logic [XY_W-1:0] start_y,
    output logic            busy,
`ifdef HEX_FIELD_EN
    input  logic [31:0]     hex_val,
`endif
    output logic            frame_done
);

    localparam logic [AW:0]     LEN_MAX = (AW + 1)'(MAX_CHARS);
    localparam logic [XY_W-1:0] FW      = XY_W'(FONT_W);
    localparam logic [XY_W-1:0] FH      = XY_W'(FONT_H);

    state_t state;
    state_t state_nxt;

    logic [AW-1:0]   idx;
    logic [AW:0]     len_q;
    logic            init_q;
    logic            frame_q;
    logic [6:0]      ascii_q;
    logic [XY_W-1:0] x_q;
    logic [XY_W-1:0] y_q;

    logic [6:0]       ent_ascii;
    logic [COL_W-1:0] ent_col;
    logic [ROW_W-1:0] ent_row;
    logic [6:0]       glyph;
    logic [AW:0]      idx_inc;
    logic [AW:0]      len_clamp;
    logic             last;
    logic             blank;
    logic             init_rise;
    logic             start;

    assign ent_ascii = ent_data[ASCII_LSB +: ASCII_W];
    assign ent_col   = ent_data[COL_LSB +: COL_W];
    assign ent_row   = ent_data[COL_LSB + COL_W +: ROW_W];

    assign idx_inc   = {1'b0, idx} + (AW + 1)'(1);
    assign last      = idx_inc >= len_q;
    assign blank     = ent_ascii == ASCII_BLANK;
    assign len_clamp = (str_len > LEN_MAX) ? LEN_MAX : str_len;
    assign init_rise = init_done & ~init_q;
    assign start     = init_done & (refresh | (AUTO_RUN & init_rise));

`ifdef HEX_FIELD_EN
    logic [31:0] hex_q;
    logic [2:0]  nib_sel;
    logic [3:0]  nib;
    logic [6:0]  hex_ascii;

    // Nibble 7 sits at col 0 so a field reads MSB first, left to right
    assign nib_sel = 3'd7 - ent_col[2:0];
    assign nib     = hex_q[{nib_sel, 2'b00} +: 4];

    lcd_text_hex_digit u_hex_digit (
        .nibble (nib),
        .ascii  (hex_ascii)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hex_q <= '0;
        end else if (state == ST_IDLE && start) begin
            hex_q <= hex_val;
        end
    end

    always_comb begin
        glyph = ent_ascii;
        if (ent_ascii == ASCII_HEX_ESC) begin
            glyph = hex_ascii;
        end
    end
`else
    assign glyph = ent_ascii;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!init_done) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = (len_clamp == '0) ? ST_DONE : ST_RD;
                    end
                end
                ST_RD: state_nxt = ST_LAT;
                ST_LAT: begin
                    if (blank) begin
                        state_nxt = last ? ST_DONE : ST_RD;
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end
                ST_ISSUE: state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (show_char_done) begin
                        state_nxt = last ? ST_DONE : ST_RD;
                    end
                end
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx     <= '0;
            len_q   <= '0;
            init_q  <= 1'b0;
            frame_q <= 1'b0;
            ascii_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            init_q  <= init_done;
            frame_q <= init_done && state == ST_DONE;
            if (!init_done) begin
                idx <= '0;
            end else begin
                if (state == ST_IDLE && start) begin
                    idx   <= '0;
                    len_q <= len_clamp;
                end
                if ((state == ST_LAT && blank) ||
                    (state == ST_WAIT && show_char_done)) begin
                    idx <= idx_inc[AW-1:0];
                end
                // Glyph fields are held from the strobe until the next one
                if (state == ST_LAT && !blank) begin
                    ascii_q <= glyph;
                    x_q     <= XY_W'(ent_col) * FW;
                    y_q     <= XY_W'(ent_row) * FH;
                end
            end
        end
    end

    always_comb begin
        en_size        = FONT_BIG;
        ent_addr       = idx;
        show_char_flag = state == ST_ISSUE;
        busy           = state != ST_IDLE;
        frame_done     = frame_q;
        ascii_num      = ascii_q;
        start_x        = x_q;
        start_y        = y_q;
    end

endmodule
